register32: RTL and testbench
=============================

// Module: register32
// PURPOSE
//   Parallel-load, edge-triggered data register: captures a WIDTH-bit word on
//   every rising clock edge and holds it until the next edge. Basic storage
//   element for datapath pipeline and holding registers. Built from per-bit
//   D flip-flops sharing one clock and one reset.
// PARAMETERS
//   WIDTH      32     number of stored bits (legal range 1..64)
//   RST_VALUE  32'h0  value loaded into q by reset (WIDTH bits, zero-extended)
// PORTS
//   clk      input   1      rising-edge clock
//   reset_n  input   1      asynchronous reset, active low
//   d        input   WIDTH  data to capture
//   q        output  WIDTH  stored data, registered output
//   en       input   1      load enable (present only with REGISTER32_LOAD_EN)
// BEHAVIOUR
//   - Single clock domain (clk). Reset is asynchronous and active-low (reset_n).
//   - reset_n low: q = RST_VALUE immediately, independent of clk. The register
//     stays at RST_VALUE for as long as reset_n is low. Clock edges are ignored
//     while in reset.
//   - reset_n deasserted (rising): no change to q. The first capture happens on
//     the first rising clk edge with reset_n high.
//   - Rising clk edge with reset_n high: q <= d. All WIDTH bits update
//     together. Latency is one clock edge; q is stable for the full cycle.
//   - d changes between edges have no effect on q. No transparency; the block is
//     not a latch. Only the value of d at the rising edge matters.
//   - Falling clk edges have no effect.
//   - No arithmetic, no wrap-around. Each bit i of q depends only on bit i of d.
//   - Reset asserted in the same instant as a clock edge: reset wins, and
//     q = RST_VALUE.
//   - q is driven directly by flops, with no combinational path from d to q.
// CONFIGURATION
//   Macro REGISTER32_LOAD_EN:
//   - Defined: adds input port en. On a rising edge with reset_n high,
//     q <= d when en=1; q holds its value when en=0. Reset behaviour is
//     unchanged and ignores en.
//   - Undefined: no en port. The register loads d on every rising edge.
// TESTING
//   Bench: clk period 10 ns, first rising edge at 5 ns. d changes every 7 ns,
//   which puts it asynchronous to clk.
//   1. reset_n=0 with d=32'hFFFFFFFF, clk toggling
//      -> q=32'h00000000 throughout; q goes to 0 within the same timestep as
//      reset assertion.
//   2. reset_n=1; d=32'h12345678 at 0 ns, d=32'h98765432 at 7 ns,
//      d=32'hFFEEDDCC at 14 ns
//      -> q=32'h12345678 after the 5 ns edge; q=32'hFFEEDDCC after the 15 ns
//      edge. 32'h98765432 is never seen on q.
//   3. d=32'hBBAABBAA at 21 ns, d=32'h77665544 at 28 ns
//      -> q=32'hBBAABBAA after the 25 ns edge; q holds that value until the
//      next edge.
//   4. d=32'h33221100 at 36 ns, d=32'h12345678 at 42 ns
//      -> q=32'h33221100 after the 35+10=45 ns edge is NOT the expected result;
//      the expected result is q=32'h12345678 after the 45 ns edge.
//   5. Pulse reset_n low for 2 ns mid-cycle with q=32'h12345678
//      -> q=0 immediately; q=d at the next rising edge after release.
//   6. REGISTER32_LOAD_EN defined; en=0, d=32'hA5A5A5A5 for 3 edges
//      -> q unchanged. Then en=1 -> q=32'hA5A5A5A5 at the next edge.

Source files
------------

// File: rtl/register32.sv
// ---------------------------------------------------------------------------
// register32 - parallel-load, edge-triggered data register
//
// Captures a WIDTH-bit word on every rising clk edge and holds it until the
// next edge. Each bit is its own D flip-flop, and all bits share one clock
// and one reset.
//
// Optional feature macro: REGISTER32_LOAD_EN
//   undefined (default) : q loads d on every rising edge
//   defined             : adds input en; q loads d only when en=1, holds
//                         otherwise. Reset ignores en.
//
// Parameters
//   WIDTH      number of stored bits (1..64), default 32
//   RST_VALUE  value forced onto q while reset_n is low
//
// Ports
//   clk      in   1      rising-edge clock
//   reset_n  in   1      asynchronous reset, active low
//   d        in   WIDTH  data to capture
//   en       in   1      load enable (REGISTER32_LOAD_EN builds only)
//   q        out  WIDTH  stored data, driven straight from the flops
// ---------------------------------------------------------------------------
module register32 #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef REGISTER32_LOAD_EN
  input  logic             en,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;

`ifdef REGISTER32_LOAD_EN
  // Hold is a mux back onto the flop input, so the clock is never gated.
  assign q_next = en ? d : q_reg;
`else
  assign q_next = d;
`endif

  // One flop per bit. Bit gi depends only on bit gi of d, so there is no
  // path between bits.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          q_reg[gi] <= RST_VALUE[gi];
        end else begin
          q_reg[gi] <= q_next[gi];
        end
      end
    end
  endgenerate

  assign q = q_reg;

endmodule

// File: tb/tb_register32.sv
// ---------------------------------------------------------------------------
// tb_register32 - self-checking bench for register32
//
// clk period 10 ns, first rising edge at 5 ns. d is changed only at times
// that never coincide with a rising edge. Every rising edge with reset_n
// high pushes the expected q into a scoreboard queue; 1 ns later it is
// popped and compared. Falling edges check that q is held.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_register32;

  localparam int          WIDTH = 32;
  localparam logic [31:0] RST   = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             en = 1'b1;
  logic [WIDTH-1:0] d = '1;
  logic [WIDTH-1:0] q;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [WIDTH-1:0] cur_exp = RST;
  logic [WIDTH-1:0] sb[$];

  register32 #(.WIDTH(WIDTH), .RST_VALUE(RST)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef REGISTER32_LOAD_EN
    .en      (en),
`endif
    .d       (d),
    .q       (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("t=%0t %s q=%08h ok", $time, tag, got);
    end else begin
      $display("t=%0t FAIL %s q=%08h expected %08h", $time, tag, got, exp);
    end
  endtask

  // Reset forces the expected value at once, independent of the clock.
  always @(negedge reset_n) cur_exp = RST;

  // Scoreboard: push at the edge, pop and compare 1 ns later.
  always @(posedge clk) begin
    logic [WIDTH-1:0] exp_v;
    if (reset_n) begin
`ifdef REGISTER32_LOAD_EN
      if (en) cur_exp = d;
`else
      cur_exp = d;
`endif
      sb.push_back(cur_exp);
    end
    #1;
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      check("edge", q, exp_v);
    end else begin
      check("in_reset", q, RST);
    end
  end

  // Falling edges must not disturb q.
  always @(negedge clk) check("hold", q, cur_exp);

  initial begin
    // 1: reset with d all ones; q must drop in the same instant.
    d = 32'hFFFF_FFFF;
    #0.5 reset_n = 1'b0;
    #0.1 check("rst_async", q, RST);
    #97.4 reset_n = 1'b1;                 // t=98, mid-cycle release
    #1   check("rst_release", q, RST);    // t=99, no change on release
    // 2..4: spec timeline shifted by 100 ns (edges at 105, 115, ...)
    #1 d = 32'h1234_5678;                 // 100
    #7 d = 32'h9876_5432;                 // 107
    #7 d = 32'hFFEE_DDCC;                 // 114
    #7 d = 32'hBBAA_BBAA;                 // 121
    #7 d = 32'h7766_5544;                 // 128
    #8 d = 32'h3322_1100;                 // 136
    #6 d = 32'h1234_5678;                 // 142
    #4 check("t4_q", q, 32'h1234_5678);   // 146, after 145 edge
    // 5: 2 ns reset pulse mid-cycle
    #1 reset_n = 1'b0;                    // 147
    #0.1 check("rst_pulse", q, RST);
    #1.9 reset_n = 1'b1;                  // 149
    // random data, two changes per cycle; only the last before an edge counts
    for (int i = 0; i < 20; i++) begin
      #2 d = $urandom;
      #5 d = $urandom;
      #3;
    end
`ifdef REGISTER32_LOAD_EN
    // 6: en=0 holds across three edges, en=1 loads on the next one.
    #2 begin en = 1'b0; d = 32'hA5A5_A5A5; end  // 351
    #30 en = 1'b1;                               // 381
    #10 check("en_load", q, 32'hA5A5_A5A5);      // 391
`endif
    #12;
    check("sb_empty", WIDTH'(sb.size()), '0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
